// File: rtl/game_flow_pkg.sv
// game_flow_pkg: state encoding and sizing helpers shared by game_flow_ctrl,
// its interface, its frame timer and the testbench.
// Contents: game_state_t, frame_cnt_w(), FRAME_CNT_W_DEFAULT.
package game_flow_pkg;

  typedef enum logic [2:0] {
    GS_TITLE,
    GS_PLAY,
    GS_DYING,
    GS_RESPAWN,
    GS_OVER,
    GS_PAUSE
  } game_state_t;

  // Counter width able to reach the longest of the three timed durations.
  function automatic int frame_cnt_w(input int d0, input int d1, input int d2);
    int m;
    m = d0;
    if (d1 > m) m = d1;
    if (d2 > m) m = d2;
    return $clog2(m) + 1;
  endfunction

  localparam int FRAME_CNT_W_DEFAULT = frame_cnt_w(90, 60, 600);

endpackage

// File: rtl/game_flow_if.sv
// game_flow_if: bundles the per-frame inputs and sprite qualifiers of game_flow_ctrl.
// Inputs : frame_tick, start_btn, select_btn, die, score (BCD digits).
// Outputs: state, lives, title_scale, ship_visible, ship_invuln, game_reset, game_over, paused.
// master = surrounding game top (drives inputs), slave = game_flow_ctrl.
interface game_flow_if #(
  parameter int SCORE_DIGITS = 6,
  parameter int LIVES_W      = 4
);
  import game_flow_pkg::*;

  logic                         frame_tick;
  logic                         start_btn;
  logic                         select_btn;
  logic                         die;
  logic [SCORE_DIGITS-1:0][3:0] score;

  game_state_t                  state;
  logic [LIVES_W-1:0]           lives;
  logic [7:0]                   title_scale;
  logic                         ship_visible;
  logic                         ship_invuln;
  logic                         game_reset;
  logic                         game_over;
  logic                         paused;

  modport master (
    output frame_tick, start_btn, select_btn, die, score,
    input  state, lives, title_scale, ship_visible, ship_invuln, game_reset, game_over, paused
  );

  modport slave (
    input  frame_tick, start_btn, select_btn, die, score,
    output state, lives, title_scale, ship_visible, ship_invuln, game_reset, game_over, paused
  );

endinterface

// File: rtl/game_flow_frame_timer.sv
// frame_timer: counts frame ticks spent in the current game state.
// Ports: clear (state entry), hold (freeze), frame_tick, tc (terminal count),
//        count_nxt (value the counter takes this edge), done (tick arriving at tc).
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clear,
  input  logic         hold,
  input  logic         frame_tick,
  input  logic [W-1:0] tc,
  output logic [W-1:0] count_nxt,
  output logic         done
);

  logic [W-1:0] count;
  logic         step;

  assign step = frame_tick & ~hold;
  // done marks the tick that completes the tc+1'th frame in the state.
  assign done = step & (count == tc);

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (step) begin
      count_nxt = count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-timed game FSM (title/play/dying/respawn/over[/pause])
// owning the lives count, score-driven bonus lives and sprite qualifiers.
// Ports: clk, resetN (async, active low), bus (game_flow_if.slave); all outputs
// registered, one cycle after the causing input. Optional pause mode: GAME_FLOW_PAUSE_EN.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int NUM_LIVES       = 3,
  parameter int MAX_NUM_LIVES   = 10,
  parameter int SCORE_DIGITS    = 6,
  parameter int BONUS_DIGIT     = 3,
  parameter int DEATH_FRAMES    = 90,
  parameter int RESPAWN_FRAMES  = 60,
  parameter int GAMEOVER_FRAMES = 600
) (
  input  logic       clk,
  input  logic       resetN,
  game_flow_if.slave bus
);

  localparam int LIVES_W = $clog2(MAX_NUM_LIVES + 1);
  localparam int FCW     = frame_cnt_w(DEATH_FRAMES, RESPAWN_FRAMES, GAMEOVER_FRAMES);
  localparam int HI_W    = (SCORE_DIGITS - BONUS_DIGIT) * 4;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(MAX_NUM_LIVES);

  game_state_t        state, state_nxt;
  logic [LIVES_W-1:0] lives, lives_nxt, lives_inc, lives_dec;
  logic [7:0]         title_scale, title_scale_nxt;
  logic               start_q, start_edge;
  logic [HI_W-1:0]    score_hi, score_hi_q;
  logic               bonus;
  logic [FCW-1:0]     tc, cnt_nxt;
  logic               tmr_clear, tmr_hold, tmr_done;
  logic               game_reset_nxt, visible_nxt;
  logic               unused_score_lo;

  assign score_hi        = bus.score[SCORE_DIGITS-1:BONUS_DIGIT];
  assign unused_score_lo = ^bus.score[BONUS_DIGIT-1:0];
  assign start_edge      = bus.start_btn & ~start_q;

`ifdef GAME_FLOW_PAUSE_EN
  logic select_q, select_edge;
  assign select_edge = bus.select_btn & ~select_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      select_q <= 1'b1;
    end else begin
      select_q <= bus.select_btn;
    end
  end
`else
  logic unused_select;
  assign unused_select = bus.select_btn;
`endif

  // Any change of the upper score digits while a game is live is worth a life.
  assign bonus = ((state == GS_PLAY) || (state == GS_DYING) || (state == GS_RESPAWN))
                 && (score_hi != score_hi_q);
  assign lives_inc = (lives >= LIVES_MAX) ? lives : lives + LIVES_W'(1);
  assign lives_dec = (lives == '0) ? lives : lives - LIVES_W'(1);

  always_comb begin
    case (state)
      GS_DYING:   tc = FCW'(DEATH_FRAMES - 1);
      GS_RESPAWN: tc = FCW'(RESPAWN_FRAMES - 1);
      GS_OVER:    tc = FCW'(GAMEOVER_FRAMES - 1);
      default:    tc = '1;
    endcase
  end

  assign tmr_clear = (state_nxt != state);
  assign tmr_hold  = (state == GS_PAUSE);

  frame_timer #(.W(FCW)) u_timer (
    .clk        (clk),
    .resetN     (resetN),
    .clear      (tmr_clear),
    .hold       (tmr_hold),
    .frame_tick (bus.frame_tick),
    .tc         (tc),
    .count_nxt  (cnt_nxt),
    .done       (tmr_done)
  );

  always_comb begin
    state_nxt      = state;
    lives_nxt      = lives;
    game_reset_nxt = 1'b0;
    case (state)
      GS_TITLE: begin
        if (start_edge) begin
          state_nxt      = GS_PLAY;
          lives_nxt      = LIVES_INIT;
          game_reset_nxt = 1'b1;
        end
      end
      GS_PLAY: begin
        if (bus.die) begin
          state_nxt = GS_DYING;
          // A bonus on the death cycle cancels the lost life.
          if (!bonus) lives_nxt = lives_dec;
        end else begin
          if (bonus) lives_nxt = lives_inc;
`ifdef GAME_FLOW_PAUSE_EN
          if (select_edge) state_nxt = GS_PAUSE;
`endif
        end
      end
      GS_DYING: begin
        if (bonus) lives_nxt = lives_inc;
        if (tmr_done) state_nxt = (lives_nxt == '0) ? GS_OVER : GS_RESPAWN;
      end
      GS_RESPAWN: begin
        if (bonus) lives_nxt = lives_inc;
        if (tmr_done) state_nxt = GS_PLAY;
      end
      GS_OVER: begin
        if (start_edge) begin
          state_nxt      = GS_PLAY;
          lives_nxt      = LIVES_INIT;
          game_reset_nxt = 1'b1;
        end else if (tmr_done) begin
          state_nxt = GS_TITLE;
        end
      end
      GS_PAUSE: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (select_edge) state_nxt = GS_PLAY;
`else
        state_nxt = GS_TITLE;
`endif
      end
      default: state_nxt = GS_TITLE;
    endcase
  end

  always_comb begin
    title_scale_nxt = '0;
    if ((state == GS_TITLE) && (state_nxt == GS_TITLE)) begin
      title_scale_nxt = (bus.frame_tick && (title_scale != 8'hFF)) ? title_scale + 8'd1
                                                                   : title_scale;
    end
  end

  // Respawn blink follows bit 3 of the frame count the state will hold next cycle.
  assign visible_nxt = (state_nxt == GS_PLAY) || (state_nxt == GS_PAUSE) ||
                       ((state_nxt == GS_RESPAWN) && |(cnt_nxt & FCW'(8)));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= GS_TITLE;
      lives            <= LIVES_INIT;
      title_scale      <= '0;
      start_q          <= 1'b1;
      score_hi_q       <= '0;
      bus.ship_visible <= 1'b0;
      bus.ship_invuln  <= 1'b0;
      bus.game_reset   <= 1'b0;
      bus.game_over    <= 1'b0;
      bus.paused       <= 1'b0;
    end else begin
      state            <= state_nxt;
      lives            <= lives_nxt;
      title_scale      <= title_scale_nxt;
      start_q          <= bus.start_btn;
      score_hi_q       <= score_hi;
      bus.ship_visible <= visible_nxt;
      bus.ship_invuln  <= (state_nxt == GS_RESPAWN);
      bus.game_reset   <= game_reset_nxt;
      bus.game_over    <= (state_nxt == GS_OVER);
      bus.paused       <= (state_nxt == GS_PAUSE);
    end
  end

  assign bus.state       = state;
  assign bus.lives       = lives;
  assign bus.title_scale = title_scale;

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
module tb_game_flow_ctrl;
  import game_flow_pkg::*;

  localparam int NUM_LIVES = 3;
  localparam int MAX_LIVES = 10;
  localparam int DIGITS    = 6;
  localparam int BONUS_DIG = 3;
  localparam int DEATH     = 90;
  localparam int RESP      = 60;
  localparam int OVER_T    = 600;
  localparam int LIVES_W   = 4;
`ifdef GAME_FLOW_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN;
  always #20 clk = ~clk;

  game_flow_if #(.SCORE_DIGITS(DIGITS), .LIVES_W(LIVES_W)) bus ();

  game_flow_ctrl #(
    .NUM_LIVES(NUM_LIVES), .MAX_NUM_LIVES(MAX_LIVES), .SCORE_DIGITS(DIGITS),
    .BONUS_DIGIT(BONUS_DIG), .DEATH_FRAMES(DEATH), .RESPAWN_FRAMES(RESP),
    .GAMEOVER_FRAMES(OVER_T)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks;
  int errors;
  int cur_score;

  // Reference model: game rules in terms of ticks spent in a state and the
  // integer value of the score above the bonus digit.
  game_state_t m_state;
  int  m_lives, m_scale, m_ticks, m_hi;
  bit  m_vis, m_inv, m_rst, m_over, m_paused, m_pstart, m_psel;

  function automatic logic [DIGITS*4-1:0] to_bcd(input int v);
    logic [DIGITS*4-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat_inc(input int l);
    return (l < MAX_LIVES) ? l + 1 : MAX_LIVES;
  endfunction

  task automatic model_reset();
    m_state = GS_TITLE; m_lives = NUM_LIVES; m_scale = 0; m_ticks = 0; m_hi = 0;
    m_vis = 0; m_inv = 0; m_rst = 0; m_over = 0; m_paused = 0;
    m_pstart = 1; m_psel = 1;
  endtask

  task automatic model_step(input bit t, input bit s, input bit sel, input bit d, input int sc);
    game_state_t ns;
    int nl, hi;
    bit sedge, seledge, bonus;
    hi      = sc / (10 ** BONUS_DIG);
    bonus   = (m_state == GS_PLAY || m_state == GS_DYING || m_state == GS_RESPAWN) && (hi != m_hi);
    sedge   = s && !m_pstart;
    seledge = PAUSE_EN && sel && !m_psel;
    ns = m_state; nl = m_lives; m_rst = 0;
    case (m_state)
      GS_TITLE, GS_OVER: begin
        if (sedge) begin
          ns = GS_PLAY; nl = NUM_LIVES; m_rst = 1;
        end else if (m_state == GS_OVER && t && m_ticks + 1 == OVER_T) begin
          ns = GS_TITLE;
        end
      end
      GS_PLAY: begin
        if (d) begin
          ns = GS_DYING;
          nl = bonus ? m_lives : ((m_lives > 0) ? m_lives - 1 : 0);
        end else begin
          if (bonus) nl = sat_inc(m_lives);
          if (seledge) ns = GS_PAUSE;
        end
      end
      GS_DYING: begin
        if (bonus) nl = sat_inc(m_lives);
        if (t && m_ticks + 1 == DEATH) ns = (nl == 0) ? GS_OVER : GS_RESPAWN;
      end
      GS_RESPAWN: begin
        if (bonus) nl = sat_inc(m_lives);
        if (t && m_ticks + 1 == RESP) ns = GS_PLAY;
      end
      GS_PAUSE: if (seledge) ns = GS_PLAY;
      default: ns = GS_TITLE;
    endcase
    if (ns != m_state) m_ticks = 0;
    else if (t && m_state != GS_PAUSE) m_ticks++;
    if (m_state == GS_TITLE && ns == GS_TITLE) begin
      if (t && m_scale < 255) m_scale++;
    end else if (ns != GS_TITLE) begin
      m_scale = 0;
    end
    m_state  = ns;
    m_lives  = nl;
    m_vis    = (ns == GS_PLAY) || (ns == GS_PAUSE) || (ns == GS_RESPAWN && (m_ticks / 8) % 2 == 1);
    m_inv    = (ns == GS_RESPAWN);
    m_over   = (ns == GS_OVER);
    m_paused = (ns == GS_PAUSE);
    m_pstart = s; m_psel = sel; m_hi = hi;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [19:0] got, want;
    got  = {bus.state, bus.lives, bus.title_scale, bus.ship_visible, bus.ship_invuln,
            bus.game_reset, bus.game_over, bus.paused};
    want = {m_state, 4'(m_lives), 8'(m_scale), m_vis, m_inv, m_rst, m_over, m_paused};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s model {state,lives,scale,vis,inv,rst,over,paused}: got %h expected %h at %0t",
               tag, got, want, $time);
    end
  endtask

  // One clock: drive at negedge, model advances on the posedge, compare at next negedge.
  task automatic step(input string tag, input bit t, input bit s, input bit sel, input bit d);
    bus.frame_tick = t; bus.start_btn = s; bus.select_btn = sel; bus.die = d;
    bus.score = to_bcd(cur_score);
    @(posedge clk);
    model_step(t, s, sel, d, cur_score);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic run_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lose_life();
    step("die", 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks("dying", DEATH);
    run_ticks("respawn", RESP);
  endtask

  task automatic apply_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    chk_model("async_reset");
    chk("mid_reset_state", bus.state, GS_TITLE);
    chk("mid_reset_game_reset", bus.game_reset, 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  typedef struct {
    bit t, s, sel, d;
    int sc;
    game_state_t st;
    int lv, scl;
    bit rst, vis;
  } vec_t;

  vec_t vt[12];
  bit   r_start, r_sel, r_die, r_tick;

  initial begin
    checks = 0; errors = 0; cur_score = 0;
    r_start = 0; r_sel = 0;
    resetN = 1'b0;
    bus.frame_tick = 0; bus.start_btn = 1; bus.select_btn = 0; bus.die = 0;
    bus.score = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", bus.state, GS_TITLE);
    chk("reset_lives", bus.lives, NUM_LIVES);
    chk("reset_scale", bus.title_scale, 0);
    chk("reset_vis", bus.ship_visible, 0);
    chk("reset_invuln", bus.ship_invuln, 0);
    chk("reset_game_reset", bus.game_reset, 0);
    chk("reset_game_over", bus.game_over, 0);
    chk("reset_paused", bus.paused, 0);
    resetN = 1'b1;

    // Start held through reset, then a real press, bonus, death and bonus in DYING.
    vt[0]  = '{0, 1, 0, 0, 0,    GS_TITLE, 3, 0, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 0,    GS_TITLE, 3, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0,    GS_TITLE, 3, 1, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 0,    GS_PLAY,  3, 0, 1, 1};
    vt[4]  = '{1, 1, 0, 0, 0,    GS_PLAY,  3, 0, 0, 1};
    vt[5]  = '{0, 0, 0, 0, 999,  GS_PLAY,  3, 0, 0, 1};
    vt[6]  = '{0, 0, 0, 0, 1000, GS_PLAY,  4, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 0, 1000, GS_PLAY,  4, 0, 0, 1};
    vt[8]  = '{0, 1, 0, 0, 1000, GS_PLAY,  4, 0, 0, 1};
    vt[9]  = '{0, 1, 0, 1, 1000, GS_DYING, 3, 0, 0, 0};
    vt[10] = '{0, 0, 0, 1, 1000, GS_DYING, 3, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 2000, GS_DYING, 4, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cur_score = vt[i].sc;
      step($sformatf("vec%0d", i), vt[i].t, vt[i].s, vt[i].sel, vt[i].d);
      chk($sformatf("vec%0d_state", i), bus.state, vt[i].st);
      chk($sformatf("vec%0d_lives", i), bus.lives, vt[i].lv);
      chk($sformatf("vec%0d_scale", i), bus.title_scale, vt[i].scl);
      chk($sformatf("vec%0d_game_reset", i), bus.game_reset, vt[i].rst);
      chk($sformatf("vec%0d_vis", i), bus.ship_visible, vt[i].vis);
    end

    // Exactly DEATH ticks in DYING, then RESPAWN blink with die held.
    run_ticks("dying", DEATH - 1);
    chk("dying_last_tick_state", bus.state, GS_DYING);
    step("dying_end", 1, 0, 0, 0);
    chk("respawn_entry_state", bus.state, GS_RESPAWN);
    chk("respawn_entry_invuln", bus.ship_invuln, 1);
    for (int k = 1; k <= RESP; k++) begin
      step("respawn", 1, 0, 0, k < RESP);
      if (k < RESP) chk($sformatf("blink_tick%0d", k), bus.ship_visible, (k / 8) % 2);
    end
    chk("respawn_exit_state", bus.state, GS_PLAY);
    chk("respawn_exit_lives", bus.lives, 4);
    chk("respawn_exit_invuln", bus.ship_invuln, 0);

    // Bonus lives saturate at MAX_LIVES.
    for (int i = 3; i <= 10; i++) begin
      cur_score = i * 1000;
      step("bonus", 0, 0, 0, 0);
      chk($sformatf("bonus_lives_%0d", i), bus.lives, (i + 2 < MAX_LIVES) ? i + 2 : MAX_LIVES);
    end

    // Mid-game reset, new game, lose down to one life, die+bonus, then game over.
    apply_reset();
    step("gap", 0, 0, 0, 0);
    step("start2", 0, 1, 0, 0);
    chk("start2_state", bus.state, GS_PLAY);
    chk("start2_game_reset", bus.game_reset, 1);
    chk("start2_lives", bus.lives, NUM_LIVES);
    lose_life();
    lose_life();
    chk("one_life_state", bus.state, GS_PLAY);
    chk("one_life_lives", bus.lives, 1);
    cur_score = cur_score + 1000;
    step("die_bonus", 0, 0, 0, 1);
    chk("die_bonus_state", bus.state, GS_DYING);
    chk("die_bonus_lives", bus.lives, 1);
    run_ticks("dying", DEATH);
    chk("die_bonus_respawn", bus.state, GS_RESPAWN);
    run_ticks("respawn", RESP);
    step("last_die", 0, 0, 0, 1);
    chk("last_die_lives", bus.lives, 0);
    run_ticks("dying", DEATH - 1);
    chk("last_dying_state", bus.state, GS_DYING);
    step("to_over", 1, 0, 0, 0);
    chk("over_state", bus.state, GS_OVER);
    chk("over_banner", bus.game_over, 1);

    // Start at tick 100 of OVER restarts the game.
    run_ticks("over", 100);
    step("over_start", 0, 1, 0, 0);
    chk("over_start_state", bus.state, GS_PLAY);
    chk("over_start_game_reset", bus.game_reset, 1);
    chk("over_start_lives", bus.lives, NUM_LIVES);
    step("over_start_rel", 0, 0, 0, 0);
    chk("game_reset_one_cycle", bus.game_reset, 0);

    // Game over left alone: exactly OVER_T ticks, then title zoom saturates.
    lose_life();
    lose_life();
    step("die3", 0, 0, 0, 1);
    run_ticks("dying", DEATH);
    run_ticks("over", OVER_T - 1);
    chk("over_hold_state", bus.state, GS_OVER);
    step("over_end", 1, 0, 0, 0);
    chk("title_state", bus.state, GS_TITLE);
    chk("title_scale_zero", bus.title_scale, 0);
    chk("title_banner_off", bus.game_over, 0);
    run_ticks("title", 10);
    chk("title_scale_10", bus.title_scale, 10);
    run_ticks("title", 250);
    chk("title_scale_sat", bus.title_scale, 255);
    run_ticks("title", 5);
    chk("title_scale_hold", bus.title_scale, 255);

    // Select / pause.
    step("start3", 0, 1, 0, 0);
    step("select", 0, 0, 1, 0);
`ifdef GAME_FLOW_PAUSE_EN
    chk("pause_state", bus.state, GS_PAUSE);
    chk("pause_flag", bus.paused, 1);
    chk("pause_vis", bus.ship_visible, 1);
    cur_score = cur_score + 1000;
    step("pause_die", 1, 0, 1, 1);
    chk("pause_die_state", bus.state, GS_PAUSE);
    chk("pause_lives", bus.lives, NUM_LIVES);
    step("pause_rel", 0, 0, 0, 0);
    step("unpause", 0, 0, 1, 0);
    chk("unpause_state", bus.state, GS_PLAY);
    chk("unpause_flag", bus.paused, 0);
    chk("unpause_lives", bus.lives, NUM_LIVES);
`else
    chk("select_ignored_state", bus.state, GS_PLAY);
    chk("select_ignored_paused", bus.paused, 0);
    step("select_rel", 0, 0, 0, 0);
    step("select2", 0, 0, 1, 0);
    chk("select2_state", bus.state, GS_PLAY);
    chk("select2_paused", bus.paused, 0);
`endif

    // Random play against the model, with one asynchronous reset in the middle.
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) apply_reset();
      r_tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) r_start = ~r_start;
      if ($urandom_range(0, 39) == 0) r_sel = ~r_sel;
      r_die = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) cur_score = (cur_score + $urandom_range(1, 1500)) % 1000000;
      step("random", r_tick, r_start, r_sel, r_die);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
